voltage_to_adc_code: RTL and testbench
======================================

Name: voltage_to_adc_code

Overview:
- Converts a user-entered decimal voltage X.YZ V into the equivalent 12-bit ADC code. This is the inverse of the existing ADC-code-to-digits conversion.
- Used by the trigger-level / cursor path: the UI supplies digits, and this block returns the threshold code that the comparators compare against raw ADC samples.
- Computes code = floor(mV * 2^ADC_BITS / VREF_MV) with a multi-cycle restoring divider behind a start/busy/done handshake.

Parameters:
- VREF_MV, 5000, full-scale reference in millivolts.
- ADC_BITS, 12, ADC code width.
- MV_W, $clog2(VREF_MV+1) = 13, width of the clamped millivolt value (derived, localparam).
- NUM_W, MV_W+ADC_BITS = 25, dividend width. Also sets the number of divide iterations (derived, localparam).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a conversion. Sampled only in IDLE.
- integer_digit  in  4  volts digit, 0-9.
- float1_digit  in  4  tenths digit, 0-9.
- float2_digit  in  4  hundredths digit, 0-9.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; adc_code and the flags are valid from this cycle on.
- adc_code  out  ADC_BITS  result, held until the next done.
- sat  out  1  result saturated to the maximum code.
- err  out  1  invalid input (digit > 9 or value > VREF_MV).

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. It is checked on every clk edge and has priority over everything else.
- Reset values: state=IDLE, busy=0, done=0, adc_code=0, sat=0, err=0.
- Reset mid-conversion aborts the operation. No done is produced and outputs return to reset values.
- IDLE: when start=1, latch the three digits into input registers, go to LOAD, and set busy=1.
- start is ignored in every state other than IDLE. No queueing.
- LOAD (1 cycle):
  - mv = integer_digit*1000 + float1_digit*100 + float2_digit*10, computed 14 bits wide with no overflow (max 9990).
  - If any digit > 9: err_next=1, force_zero=1.
  - Else if mv > VREF_MV: err_next=1, clamp mv to VREF_MV.
  - Dividend = mv << ADC_BITS (NUM_W bits). Divisor = VREF_MV. Clear remainder and quotient.
- DIVIDE (exactly NUM_W cycles): restoring division, one dividend bit per cycle, MSB first.
  - rem = {rem, next bit}; if rem >= VREF_MV then subtract and shift in quotient bit 1, else shift in 0.
  - Remainder is MV_W+1 bits wide.
- DONE (1 cycle):
  - done=1, busy=0. Then return to IDLE. A start on this cycle is ignored; start may be accepted again the following cycle.
  - If force_zero: adc_code=0, sat=0.
  - Else if quotient > 2^ADC_BITS-1: adc_code = 2^ADC_BITS-1 (4095), sat=1.
  - Else: adc_code = quotient[ADC_BITS-1:0], sat=0.
  - err = err_next.
  - adc_code, sat and err are updated on the same edge that raises done, and hold until the next DONE.
- Latency: start sampled high at edge t gives done high in the cycle following edge t+NUM_W+2. That is 27 cycles with the defaults. The latency is fixed and does not depend on input values.
- Rounding: truncation (floor). Round-trip code -> digits -> code may be lower by 1 LSB; this is accepted.
- Boundary results:
  - mv = 0 gives code 0.
  - mv = VREF_MV gives a quotient of 4096, which saturates to 4095 with sat=1, err=0.
  - mv > VREF_MV gives 4095 with sat=1, err=1.

Decomposition:
- Shared package osc_pkg: VREF_MV, ADC_BITS, derived MV_W/NUM_W, and the state encoding (IDLE, LOAD, DIVIDE, DONE). The existing forward conversion block must use the same VREF_MV and ADC_BITS.
- Sub-module seq_udiv: a parameterised unsigned restoring divider (dividend width, divisor width) with a start/done handshake. voltage_to_adc_code keeps the FSM, digit decode, validation and saturation.

Test Plan:
- Digits 2,5,0 (2.50 V), one start pulse -> busy high for 26 cycles, done at t+27, adc_code=2048, sat=0, err=0.
- Digits 1,2,3 (1.23 V) -> adc_code=1007 (floor of 1007.6). Digits 0,0,1 (0.01 V) -> adc_code=8. Digits 0,0,0 -> 0.
- Digits 5,0,0 -> adc_code=4095, sat=1, err=0. Digits 6,0,0 -> adc_code=4095, sat=1, err=1. Digits 3,A(10),0 -> adc_code=0, err=1. All three cases complete with done at exactly t+27.
- Start held high continuously, and digits changed while busy -> exactly one done per 28 cycles (accepted at IDLE only). Each result matches the digits latched at acceptance.
- rst asserted at cycle 10 of DIVIDE -> next edge: busy=0, adc_code=0, no done pulse. A new start after reset gives the correct result with full latency.
- Sweep all 501 valid values 0.00-5.00 V -> adc_code == floor(mv*4096/5000), saturated at 4095, compared against a reference model.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared oscilloscope constants, FSM encoding and digit helpers.
// Used by both the code-to-digits and digits-to-code conversion paths.
package osc_pkg;

  localparam int VREF_MV   = 5000;
  localparam int ADC_BITS  = 12;
  localparam int MV_W      = $clog2(VREF_MV + 1);
  localparam int NUM_W     = MV_W + ADC_BITS;
  localparam int MV_CALC_W = 14;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DIVIDE,
    DONE
  } state_t;

  typedef struct packed {
    logic [3:0] int_d;
    logic [3:0] f1_d;
    logic [3:0] f2_d;
  } digits_t;

  // Wide enough for 9.99 V; out-of-range digits are flagged separately.
  function automatic logic [MV_CALC_W-1:0] digits_to_mv(input digits_t d);
    return MV_CALC_W'(d.int_d) * MV_CALC_W'(1000)
         + MV_CALC_W'(d.f1_d)  * MV_CALC_W'(100)
         + MV_CALC_W'(d.f2_d)  * MV_CALC_W'(10);
  endfunction

  function automatic logic digits_bad(input digits_t d);
    return (d.int_d > 4'd9) || (d.f1_d > 4'd9) || (d.f2_d > 4'd9);
  endfunction

endpackage

// File: rtl/seq_udiv.sv
// Unsigned restoring divider, one dividend bit per cycle MSB first; NW cycles after start.
// done is high during the final iteration; quotient is valid from the following cycle.
module seq_udiv #(
  parameter int NW = 25,
  parameter int DW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          done,
  output logic [NW-1:0] quotient
);

  localparam int CW = $clog2(NW + 1);

  logic [NW-1:0] dvd_q;
  logic [DW-1:0] dsr_q;
  logic [DW-1:0] rem_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;

  logic [DW:0]   rem_shift;
  logic          rem_ge;
  logic [DW-1:0] rem_next;

  // Partial remainder stays below the divisor, so the difference fits in DW bits.
  always_comb begin
    rem_shift = {rem_q, dvd_q[NW-1]};
    rem_ge    = (rem_shift >= {1'b0, dsr_q});
    rem_next  = rem_ge ? (rem_shift[DW-1:0] - dsr_q) : rem_shift[DW-1:0];
  end

  assign done = run_q && (cnt_q == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      quotient <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start) begin
      dvd_q    <= dividend;
      dsr_q    <= divisor;
      rem_q    <= '0;
      quotient <= '0;
      cnt_q    <= CW'(NW);
      run_q    <= 1'b1;
    end else if (run_q) begin
      dvd_q    <= {dvd_q[NW-2:0], 1'b0};
      rem_q    <= rem_next;
      quotient <= {quotient[NW-2:0], rem_ge};
      cnt_q    <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/voltage_to_adc_code.sv
// Converts X.YZ V digits to floor(mV * 2^ADC_BITS / VREF_MV); fixed 27-cycle start-to-done latency.
// start is only taken in IDLE (no queueing); result and flags hold until the next done.
module voltage_to_adc_code
  import osc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          integer_digit,
  input  logic [3:0]          float1_digit,
  input  logic [3:0]          float2_digit,
  output logic                busy,
  output logic                done,
  output logic [ADC_BITS-1:0] adc_code,
  output logic                sat,
  output logic                err
);

  state_t  state_q, state_d;
  digits_t digits_q;
  logic    err_next_q;
  logic    force_zero_q;

  logic [MV_CALC_W-1:0] mv_raw;
  logic                 mv_over;
  logic                 digit_bad;
  logic [MV_W-1:0]      mv_clamp;
  logic [NUM_W-1:0]     dividend;
  logic                 div_start;
  logic                 div_done;
  logic [NUM_W-1:0]     div_quo;
  logic                 quo_over;

  always_comb begin
    mv_raw    = digits_to_mv(digits_q);
    digit_bad = digits_bad(digits_q);
    mv_over   = (mv_raw > MV_CALC_W'(VREF_MV));
    mv_clamp  = mv_over ? MV_W'(VREF_MV) : mv_raw[MV_W-1:0];
    dividend  = {mv_clamp, {ADC_BITS{1'b0}}};
    div_start = (state_q == LOAD);
    quo_over  = |div_quo[NUM_W-1:ADC_BITS];
  end

  seq_udiv #(
    .NW(NUM_W),
    .DW(MV_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (MV_W'(VREF_MV)),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = DIVIDE;
      DIVIDE:  if (div_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      digits_q     <= '0;
      err_next_q   <= 1'b0;
      force_zero_q <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      adc_code     <= '0;
      sat          <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            digits_q <= {integer_digit, float1_digit, float2_digit};
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          err_next_q   <= digit_bad | mv_over;
          force_zero_q <= digit_bad;
        end
        DIVIDE: begin
          if (div_done) busy <= 1'b0;
        end
        DONE: begin
          done <= 1'b1;
          err  <= err_next_q;
          // Full-scale input yields 2^ADC_BITS, which must pin to the top code.
          if (force_zero_q) begin
            adc_code <= '0;
            sat      <= 1'b0;
          end else if (quo_over) begin
            adc_code <= '1;
            sat      <= 1'b1;
          end else begin
            adc_code <= div_quo[ADC_BITS-1:0];
            sat      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voltage_to_adc_code.sv
// Directed bench for voltage_to_adc_code: latency, boundaries, start hold, reset abort, full sweep.
module tb_voltage_to_adc_code;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  integer_digit;
  logic [3:0]  float1_digit;
  logic [3:0]  float2_digit;
  logic        busy;
  logic        done;
  logic [11:0] adc_code;
  logic        sat;
  logic        err;

  int errors = 0;
  int checks = 0;

  voltage_to_adc_code dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .integer_digit (integer_digit),
    .float1_digit  (float1_digit),
    .float2_digit  (float2_digit),
    .busy          (busy),
    .done          (done),
    .adc_code      (adc_code),
    .sat           (sat),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One start pulse; lat = edges from acceptance to first visible done (-1 on timeout).
  task automatic run_conv(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          output int lat, output int bcnt, output int code,
                          output int s, output int e);
    lat = -1; bcnt = 0; code = -1; s = -1; e = -1;
    @(negedge clk);
    integer_digit = a; float1_digit = b; float2_digit = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy) bcnt++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (done) begin
        lat = k; code = adc_code; s = sat; e = err;
        break;
      end
    end
  endtask

  initial begin
    int lat, bcnt, code, s, e;
    int ndone, d0c, d1c, c0, c1;
    int mv, exp_code;

    rst = 1'b1; start = 1'b0;
    integer_digit = 4'd0; float1_digit = 4'd0; float2_digit = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset code", adc_code, 0);
    chk("reset sat", sat, 0);
    chk("reset err", err, 0);
    @(negedge clk); rst = 1'b0;

    run_conv(4'd2, 4'd5, 4'd0, lat, bcnt, code, s, e);
    chk("2.50 latency", lat, 27);
    chk("2.50 busy cycles", bcnt, 26);
    chk("2.50 code", code, 2048);
    chk("2.50 sat", s, 0);
    chk("2.50 err", e, 0);
    chk("busy low at done", busy, 0);

    run_conv(4'd1, 4'd2, 4'd3, lat, bcnt, code, s, e);
    chk("1.23 latency", lat, 27);
    chk("1.23 code", code, 1007);

    run_conv(4'd0, 4'd0, 4'd1, lat, bcnt, code, s, e);
    chk("0.01 code", code, 8);
    chk("0.01 err", e, 0);

    run_conv(4'd0, 4'd0, 4'd0, lat, bcnt, code, s, e);
    chk("0.00 code", code, 0);
    chk("0.00 sat", s, 0);

    run_conv(4'd5, 4'd0, 4'd0, lat, bcnt, code, s, e);
    chk("5.00 latency", lat, 27);
    chk("5.00 code", code, 4095);
    chk("5.00 sat", s, 1);
    chk("5.00 err", e, 0);

    run_conv(4'd6, 4'd0, 4'd0, lat, bcnt, code, s, e);
    chk("6.00 latency", lat, 27);
    chk("6.00 code", code, 4095);
    chk("6.00 sat", s, 1);
    chk("6.00 err", e, 1);

    run_conv(4'd3, 4'd10, 4'd0, lat, bcnt, code, s, e);
    chk("bad digit latency", lat, 27);
    chk("bad digit code", code, 0);
    chk("bad digit sat", s, 0);
    chk("bad digit err", e, 1);

    // start held high; digits change while busy and must not leak into the result
    ndone = 0; d0c = -1; d1c = -1; c0 = -1; c1 = -1;
    @(negedge clk);
    integer_digit = 4'd1; float1_digit = 4'd0; float2_digit = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 5) integer_digit = 4'd4;
      if (k == 30) start = 1'b0;
      if (k == 33) integer_digit = 4'd2;
      if (done) begin
        if (ndone == 0) begin d0c = k; c0 = adc_code; end
        else if (ndone == 1) begin d1c = k; c1 = adc_code; end
        ndone++;
      end
    end
    chk("hold done count", ndone, 2);
    chk("hold first done cycle", d0c, 27);
    chk("hold second done cycle", d1c, 55);
    chk("hold first code", c0, 819);
    chk("hold second code", c1, 3276);

    // reset during DIVIDE
    @(negedge clk);
    integer_digit = 4'd4; float1_digit = 4'd0; float2_digit = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort code", adc_code, 0);
    chk("abort sat", sat, 0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort no done", ndone, 0);
    run_conv(4'd1, 4'd2, 4'd3, lat, bcnt, code, s, e);
    chk("post-abort latency", lat, 27);
    chk("post-abort code", code, 1007);

    // every valid value 0.00 .. 5.00 V
    for (int v = 0; v <= 500; v++) begin
      mv = v * 10;
      exp_code = (mv * 4096) / 5000;
      if (exp_code > 4095) exp_code = 4095;
      run_conv(4'(v / 100), 4'((v / 10) % 10), 4'(v % 10), lat, bcnt, code, s, e);
      chk($sformatf("sweep code mv=%0d", mv), code, exp_code);
      chk($sformatf("sweep sat mv=%0d", mv), s, (mv == 5000) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
